// File: rtl/legv8_datapath_mc.sv
// legv8_datapath_mc: multi-cycle LEGv8 datapath (regfile, ALU, flags, handshaked data-memory port).
// Define MEM_TIMEOUT_EN to abort memory transactions unacknowledged after TIMEOUT cycles.
module legv8_datapath_mc #(
    parameter int WIDTH   = 64,
    parameter int REGS    = 32,
    parameter int TIMEOUT = 16,
    localparam int RA     = $clog2(REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [3*RA+9:0]   control_word,
    input  logic [WIDTH-1:0]  constant,
    output logic [4:0]        status,
    output logic [WIDTH-1:0]  data,
    output logic              data_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [RA-1:0] XZR = RA'(REGS - 1);

    typedef enum logic {IDLE, MEM} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  regs_q [REGS];
    logic [WIDTH-1:0]  regs_d [REGS];
    logic [3:0]        status_q, status_d;
    logic [WIDTH-1:0]  data_q, data_d, addr_q, addr_d, wdata_q, wdata_d;
    logic              dv_q, dv_d, we_q, we_d, rw_q, rw_d, err_q, err_d;
    logic [RA-1:0]     da_q, da_d;

    logic [RA-1:0]     sa, sb, da;
    logic              rw, mw, bsel, sl, mr;
    logic [4:0]        fs;
    logic [WIDTH-1:0]  ra, rb, ap, bp, result;
    logic [WIDTH:0]    sum;
    logic              v, c, n, z;

    assign {sa, sb, da, rw, mw, fs, bsel, sl, mr} = control_word;

    // XZR reads as zero regardless of array contents
    assign ra  = (sa == XZR) ? '0 : regs_q[sa];
    assign rb  = (sb == XZR) ? '0 : regs_q[sb];
    assign ap  = fs[1] ? ~ra : ra;
    assign bp  = fs[0] ? ~(bsel ? constant : rb) : (bsel ? constant : rb);
    assign sum = {1'b0, ap} + {1'b0, bp} + {{WIDTH{1'b0}}, fs[0]};

    always_comb begin
        result = fs[4:2] == 3'b000 ? ap & bp :
                 fs[4:2] == 3'b001 ? ap | bp :
                 fs[4:2] == 3'b010 ? sum[WIDTH-1:0] :
                 fs[4:2] == 3'b011 ? ap ^ bp :
                 fs[4:2] == 3'b100 ? ap << bp[SW-1:0] :
                 fs[4:2] == 3'b101 ? ap >> bp[SW-1:0] : '0;
        n = result[WIDTH-1];
        z = (result == '0);
        c = (fs[4:2] == 3'b010) & sum[WIDTH];
        v = (fs[4:2] == 3'b010) & (ap[WIDTH-1] == bp[WIDTH-1]) & (sum[WIDTH-1] != ap[WIDTH-1]);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        status_d = status_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rw_d     = rw_q;
        da_d     = da_q;
        err_d    = err_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        if (state_q == IDLE && cw_valid) begin
            if (sl)
                status_d = {v, c, n, z};
            if (mw | mr) begin
                state_d = MEM;
                addr_d  = result;
                wdata_d = rb;
                we_d    = mw;
                rw_d    = rw;
                da_d    = da;
`ifdef MEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end else begin
                if (rw && da != XZR)
                    regs_d[da] = result;
                data_d = result;
                dv_d   = 1'b1;
            end
        end else if (state_q == MEM) begin
            if (mem_ack) begin
                state_d = IDLE;
                if (!we_q && rw_q) begin
                    if (da_q != XZR)
                        regs_d[da_q] = mem_rdata;
                    data_d = mem_rdata;
                    dv_d   = 1'b1;
                end
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else
                cnt_d = cnt_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            for (int i = 0; i < REGS; i++)
                regs_q[i] <= '0;
            status_q <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rw_q     <= 1'b0;
            da_q     <= '0;
            err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            status_q <= status_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rw_q     <= rw_d;
            da_q     <= da_d;
            err_q    <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign cw_ready   = (state_q == IDLE);
    assign mem_req    = (state_q == MEM);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign status     = {status_q, z};
`ifdef MEM_TIMEOUT_EN
    assign mem_err    = err_q;
`else
    assign mem_err    = 1'b0;
`endif
endmodule

// File: tb/tb_legv8_datapath_mc.sv
// tb_legv8_datapath_mc: directed self-checking bench for legv8_datapath_mc (WIDTH=64, REGS=32).
module tb_legv8_datapath_mc;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cw_valid = 1'b0;
    logic        cw_ready;
    logic [24:0] control_word = '0;
    logic [63:0] constant = '0;
    logic [4:0]  status;
    logic [63:0] data;
    logic        data_valid;
    logic        mem_req, mem_we, mem_err;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [4:0] ADD = 5'b01000, SUB = 5'b01001, ORR = 5'b00100, AND = 5'b00000;

    legv8_datapath_mc #(.WIDTH(64), .REGS(32), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .control_word(control_word), .constant(constant), .status(status), .data(data),
        .data_valid(data_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    function automatic logic [24:0] cw(input logic [4:0] sa, sb, da, input logic rw, mw,
                                       input logic [4:0] fs, input logic bs, sl, mr);
        return {sa, sb, da, rw, mw, fs, bs, sl, mr};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [24:0] c, input logic [63:0] k);
        @(negedge clock);
        control_word = c;
        constant = k;
        cw_valid = 1'b1;
        @(posedge clock);
        #1 cw_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] r, input logic [63:0] exp);
        xfer(cw(r, 31, 31, 0, 0, ORR, 0, 0, 0), 0);
        check(tag, data, exp);
    endtask

    task automatic wait_req(input int ack_at, output int n);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            check("cw_ready_low_in_mem", cw_ready, 0);
            @(negedge clock);
            mem_ack = (n == ack_at);
            @(posedge clock);
            #1 mem_ack = 1'b0;
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        check("rst_status", status[4:1], 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_cw_ready", cw_ready, 1);
        check("rst_data", data, 0);
        check("rst_dv", data_valid, 0);
        check("rst_mem_err", mem_err, 0);
        @(negedge clock) reset = 1'b1;

        xfer(cw(31, 31, 1, 1, 0, ADD, 1, 1, 0), 5);
        check("add_data", data, 5);
        check("add_dv", data_valid, 1);
        check("add_status", status[4:1], 4'b0000);
        @(posedge clock) #1;
        check("add_dv_pulse", data_valid, 0);

        xfer(cw(31, 1, 0, 0, 1, ADD, 1, 0, 0), 8);
        check("st_req", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_req", mem_req, 0);
        check("midrst_ready", cw_ready, 1);
        check("midrst_status", status[4:1], 0);
        @(negedge clock) reset = 1'b1;
        rd("midrst_x1", 1, 0);
        check("midrst_nowb_dv", data_valid, 1);

        xfer(cw(31, 31, 1, 1, 0, ADD, 1, 1, 0), 5);
        xfer(cw(1, 1, 2, 1, 0, SUB, 0, 1, 0), 0);
        check("sub_data", data, 0);
        check("sub_status", status[4:1], 4'b0101);
        rd("sub_x2", 2, 0);

        xfer(cw(31, 31, 4, 1, 0, ADD, 1, 1, 0), 64'h7FFF_FFFF_FFFF_FFFF);
        check("max_status", status[4:1], 4'b0000);
        xfer(cw(4, 31, 5, 1, 0, ADD, 1, 1, 0), 1);
        check("ovf_data", data, 64'h8000_0000_0000_0000);
        check("ovf_status", status[4:1], 4'b1010);

        mem_ack = 1'b1;
        xfer(cw(31, 31, 6, 1, 0, AND, 0, 0, 0), 0);
        check("sl0_hold", status[4:1], 4'b1010);
        check("live_z", status[0], 1);
        check("ack_idle_ignored", mem_req, 0);
        mem_ack = 1'b0;

        xfer(cw(31, 1, 0, 0, 1, ADD, 1, 0, 0), 8);
        check("st_we", mem_we, 1);
        check("st_addr", mem_addr, 8);
        check("st_wdata", mem_wdata, 5);
        wait_req(3, n);
        check("st_req_cycles", n, 3);
        check("st_no_dv", data_valid, 0);

        mem_rdata = 64'hABCD;
        xfer(cw(31, 31, 3, 1, 0, ADD, 1, 0, 1), 8);
        check("ld_req", mem_req, 1);
        check("ld_we", mem_we, 0);
        check("ld_addr", mem_addr, 8);
        wait_req(1, n);
        check("ld_req_cycles", n, 1);
        check("ld_dv", data_valid, 1);
        check("ld_data", data, 64'hABCD);
        rd("ld_x3", 3, 64'hABCD);

        mem_rdata = 64'h1234;
        xfer(cw(31, 31, 31, 1, 0, ADD, 1, 0, 1), 16);
        wait_req(1, n);
        check("ldxzr_data", data, 64'h1234);
        rd("ldxzr_x31", 31, 0);
        xfer(cw(31, 31, 31, 1, 0, ADD, 1, 0, 0), 7);
        check("addxzr_data", data, 7);
        rd("addxzr_x31", 31, 0);

`ifdef MEM_TIMEOUT_EN
        mem_rdata = 64'h5555;
        xfer(cw(31, 31, 3, 1, 0, ADD, 1, 0, 1), 8);
        wait_req(0, n);
        check("to_req_cycles", n, 16);
        check("to_err", mem_err, 1);
        check("to_no_dv", data_valid, 0);
        rd("to_x3", 3, 64'hABCD);
        check("to_err_sticky", mem_err, 1);
`else
        check("err_tied", mem_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
